fifo_wr_ctrl_async: RTL
=======================

Name: fifo_wr_ctrl_async

Overview:
Finite state machine that takes bytes from the UART RX and writes them into the shared FIFO. It is the write-side counterpart of the FIFO read controller that feeds the UART TX.
- Holds one received byte.
- Waits while the FIFO is full or a FIFO read strobe is active.
- Issues a single-cycle active-low write strobe.
- Records dropped bytes in a sticky flag and a counter.
All outputs are registered, so there are no glitches and I/O constraints stay uniform.

Parameters:
WIDTH, 8, width of the RX data and FIFO write data.
TIMEOUT, 64, number of consecutive cycles in ARB with fifo_full high before the held byte is discarded (range 2..256).

Ports:
clk  input  1  primary clock
reset_n  input  1  asynchronous digital reset (active low)
rx_data  input  WIDTH  byte from UART RX, valid when rx_data_valid=1
rx_data_valid  input  1  single-cycle pulse, new RX byte present
fifo_full  input  1  high when the FIFO cannot accept a write
read_fifo_n  input  1  FIFO read strobe from the read controller (active low); a write is never issued in the same cycle
clr_overflow  input  1  synchronous clear of overflow and drop_count
write_fifo_n  output  1  FIFO write strobe (active low), one cycle per byte
fifo_wr_data  output  WIDTH  data to the FIFO, stable while write_fifo_n=0
busy  output  1  high while a byte is held
overflow  output  1  sticky, set on any dropped byte
drop_count  output  8  saturating count of dropped bytes

Behaviour:
Reset:
- Asynchronous on reset_n low.
- State=IDLE, hold_valid=0, write_fifo_n=1, fifo_wr_data=0, busy=0, overflow=0, drop_count=0, full-wait counter=0.
- A reset mid-operation discards the held byte. No write strobe is issued after reset_n deasserts until a new byte is captured.

Capture:
- On a clk edge with rx_data_valid=1 and hold_valid=0: hold_data<=rx_data and hold_valid<=1.
- If hold_valid=1 and the byte is not being retired on that edge: the new byte is dropped (overflow<=1, drop_count+1).
- If the held byte is retired on the same edge that rx_data_valid=1: the new byte is accepted and hold_valid stays 1.

States (2-bit encoding):
- IDLE (0): if hold_valid, Next=ARB; else stay.
- ARB (1), evaluated in priority order:
  - fifo_full=1: stay and increment the full-wait counter. When the counter equals TIMEOUT-1, retire the held byte as dropped (overflow<=1, drop_count+1) and Next=IDLE.
  - read_fifo_n=0: stay. The counter holds its value.
  - Otherwise: Next=WRITE.
  - The counter clears on every exit from ARB.
- WRITE (2): Next=RECOVER. The held byte is retired at the end of this state.
- RECOVER (3): write_fifo_n=1. Next=ARB if hold_valid, else IDLE. This guarantees at least one idle cycle between write strobes.

Outputs:
- Registered from Next, so write_fifo_n=0 exactly during the cycle when State=WRITE. It is never low for two consecutive cycles.
- fifo_wr_data is loaded from hold_data whenever Next=WRITE and holds its value otherwise.
- busy equals hold_valid, registered.

Latency:
- rx_data_valid sampled at edge E0 → hold_valid=1 after E0 → State=ARB after E1 → write_fifo_n=0 from E2 to E3.
- With the FIFO not full and no read active, the minimum latency is 2 cycles.
- Each cycle in ARB with fifo_full=1 or read_fifo_n=0 adds one cycle.

Arbitration:
- A read strobe always wins over a write.
- fifo_full is rechecked every ARB cycle. Full going low and read going low in the same cycle means the controller waits.

Overflow and drop counting:
- drop_count saturates at 8'hFF.
- clr_overflow=1 clears overflow and drop_count. A drop on the same edge wins, giving overflow=1 and drop_count=1.

Test Plan:
- Single byte: rx_data=8'hA5 pulse at E0, fifo_full=0, read_fifo_n=1 → write_fifo_n=0 only in the E2–E3 cycle, fifo_wr_data=8'hA5, overflow=0.
- Read collision: read_fifo_n=0 for 3 cycles starting when ARB is entered → the write is deferred 3 cycles and never overlaps read_fifo_n=0; the byte is written exactly once.
- Full timeout: fifo_full=1 held, byte 8'h3C captured → no write strobe, drop after TIMEOUT (64) cycles in ARB; overflow=1, drop_count=1, busy=0.
- Back-to-back: a second byte (8'h5A) pulses while 8'h11 is held in ARB with the FIFO full → drop_count=1. Then a byte arriving on the same edge the first retires → both writes occur, separated by at least one idle cycle.
- Saturation and clear: force 300 drops → drop_count=8'hFF. Pulse clr_overflow with a drop on the same edge → overflow=1, drop_count=1.
- Reset mid-write: assert reset_n low during ARB with a byte held → all outputs return to reset values immediately; no write strobe after release.

Source files
------------

// File: rtl/fifo_wr_ctrl_async_if.sv
// Handshake bundle between the UART RX side, the shared FIFO and the
// FIFO write controller.
interface fifo_wr_ctrl_async_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_data_valid;
  logic             fifo_full;
  logic             read_fifo_n;
  logic             clr_overflow;
  logic             write_fifo_n;
  logic [WIDTH-1:0] fifo_wr_data;
  logic             busy;
  logic             overflow;
  logic [7:0]       drop_count;

  modport master (
    output rx_data, rx_data_valid, fifo_full, read_fifo_n, clr_overflow,
    input  write_fifo_n, fifo_wr_data, busy, overflow, drop_count
  );

  modport slave (
    input  rx_data, rx_data_valid, fifo_full, read_fifo_n, clr_overflow,
    output write_fifo_n, fifo_wr_data, busy, overflow, drop_count
  );
endinterface

// File: rtl/fifo_wr_ctrl_async.sv
// FIFO write controller: holds one RX byte, arbitrates against FIFO reads and
// full, issues a one-cycle active-low write strobe, and tracks dropped bytes.
module fifo_wr_ctrl_async #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset_n,
  fifo_wr_ctrl_async_if.slave  bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    WRITE   = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             write_n_q, write_n_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic retire;
  logic timeout_drop;
  logic rx_drop;
  logic drop;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    wr_data_d    = wr_data_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    retire       = 1'b0;
    timeout_drop = 1'b0;
    rx_drop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_valid_q) state_d = ARB;
      end
      ARB: begin
        // Full outranks a pending read; only full advances the wait counter.
        if (bus.fifo_full) begin
          if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            timeout_drop = 1'b1;
            retire       = 1'b1;
            wait_cnt_d   = '0;
            state_d      = IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end else if (bus.read_fifo_n) begin
          wait_cnt_d = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        retire  = 1'b1;
        state_d = RECOVER;
      end
      RECOVER: begin
        state_d = hold_valid_q ? ARB : IDLE;
      end
    endcase

    // A byte arriving on the retiring edge refills the holding register.
    if (bus.rx_data_valid) begin
      if (!hold_valid_q || retire) begin
        hold_valid_d = 1'b1;
        hold_data_d  = bus.rx_data;
      end else begin
        rx_drop = 1'b1;
      end
    end else if (retire) begin
      hold_valid_d = 1'b0;
    end

    drop = timeout_drop | rx_drop;

    if (bus.clr_overflow) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    write_n_d = (state_d != WRITE);
    if (state_d == WRITE) wr_data_d = hold_data_q;
    busy_d = hold_valid_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      write_n_q    <= 1'b1;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      write_n_q    <= write_n_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.write_fifo_n = write_n_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.busy         = busy_q;
  assign bus.overflow     = overflow_q;
  assign bus.drop_count   = drop_cnt_q;

endmodule
